// File: rtl/force_arbiter.sv
// force_arbiter: round-robin override controller for a W-bit net.
// Grants one requester at a time, holds its value, then releases.
module force_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int LW   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [W-1:0]         func_val,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*W-1:0]    req_val,
   input  logic [NREQ*LW-1:0]   req_len,
   output logic [NREQ-1:0]      grant,
   output logic                 forced,
   output logic                 done,
   output logic [W-1:0]         out_val
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE,
      FORCE,
      RELEASE
   } state_t;

   state_t        state;
   logic [LW-1:0] cnt;
   logic [W-1:0]  hold_val;
   logic [IW-1:0] last;
   logic [IW-1:0] idx;
   logic [IW-1:0] pick;
   logic          found;
   logic [LW-1:0] pick_len;

   // Round-robin search upward from last+1, wrapping modulo NREQ.
   always_comb begin
      int j;
      logic [IW-1:0] jj;
      pick  = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int off = 1; off <= NREQ; off++) begin
         j  = (int'(last) + off) % NREQ;
         jj = IW'(j);
         if (!found && req[jj]) begin
            found = 1'b1;
            pick  = jj;
         end
      end
   end

   // A zero length still gives a one-cycle override.
   always_comb begin
      pick_len = req_len[pick*LW +: LW];
      if (pick_len == '0)
         pick_len = LW'(1);
   end

   // Net mux: the latched value wins only while an override is live.
   assign out_val = forced ? hold_val : func_val;

   // Sequencer: grant, hold for cnt cycles (or until abort), pulse done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         forced   <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         hold_val <= '0;
         last     <= IW'(NREQ - 1);
         idx      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (found) begin
                  idx         <= pick;
                  hold_val    <= req_val[pick*W +: W];
                  cnt         <= pick_len;
                  grant       <= '0;
                  grant[pick] <= 1'b1;
                  forced      <= 1'b1;
                  state       <= FORCE;
               end
            end
            FORCE: begin
               if (!req[idx] || cnt == LW'(1)) begin
                  grant  <= '0;
                  forced <= 1'b0;
                  done   <= 1'b1;
                  last   <= idx;
                  cnt    <= '0;
                  state  <= RELEASE;
               end else begin
                  cnt <= cnt - LW'(1);
               end
            end
            RELEASE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               grant  <= '0;
               forced <= 1'b0;
               done   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_force_arbiter.sv
// tb_force_arbiter: directed vectors for force_arbiter.
// Expected values are hand-derived from the timing rules.
module tb_force_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int LW   = 8;

   logic                clk;
   logic                rst;
   logic [W-1:0]        func_val;
   logic [NREQ-1:0]     req;
   logic [NREQ*W-1:0]   req_val;
   logic [NREQ*LW-1:0]  req_len;
   logic [NREQ-1:0]     grant;
   logic                forced;
   logic                done;
   logic [W-1:0]        out_val;

   int npass = 0;
   int ntot  = 0;

   force_arbiter #(.NREQ(NREQ), .W(W), .LW(LW)) dut (
      .clk      (clk),
      .rst      (rst),
      .func_val (func_val),
      .req      (req),
      .req_val  (req_val),
      .req_len  (req_len),
      .grant    (grant),
      .forced   (forced),
      .done     (done),
      .out_val  (out_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      ntot++;
      if (obs === exp)
         npass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] v,
                          input logic [LW-1:0] l);
      req_val[i*W +: W]   = v;
      req_len[i*LW +: LW] = l;
   endtask

   task automatic check_idle(input string tag, input logic [W-1:0] f);
      check({tag, "_grant"}, grant, 0);
      check({tag, "_forced"}, forced, 0);
      check({tag, "_out"}, out_val, f);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      func_val = 4'h5;
      req      = '0;
      req_val  = '0;
      req_len  = '0;
      #2;
      check_idle("rst_async", 4'h5);
      do_reset();

      for (int c = 0; c < 10; c++) begin
         tick();
         check_idle("idle", 4'h5);
         check("idle_done", done, 0);
      end

      // Single override: requester 2, len 3.
      set_req(2, 4'h1, 8'd3);
      req = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("single_grant", grant, 4'b0100);
         check("single_forced", forced, 1);
         check("single_out", out_val, 4'h1);
         check("single_nodone", done, 0);
      end
      tick();
      check("single_done", done, 1);
      check_idle("single_rel", 4'h5);
      req = '0;
      tick();
      check("single_done_gone", done, 0);
      check_idle("single_after", 4'h5);
      tick();
      check_idle("single_after2", 4'h5);

      // Round-robin with all requesters, length 1, from reset.
      do_reset();
      for (int i = 0; i < NREQ; i++)
         set_req(i, 4'(i + 8), 8'd1);
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         tick();
         check("rr_grant", grant, 32'(1 << (g % 4)));
         check("rr_out", out_val, 32'((g % 4) + 8));
         tick();
         check("rr_done", done, 1);
         check("rr_rel_grant", grant, 0);
         if (g == 4)
            req = '0;
         tick();
         check("rr_idle_grant", grant, 0);
         check("rr_idle_done", done, 0);
      end

      // Zero length on requester 1 (last served was 0).
      set_req(1, 4'h7, 8'd0);
      req = 4'b0010;
      tick();
      check("zero_grant", grant, 4'b0010);
      check("zero_out", out_val, 4'h7);
      tick();
      check("zero_done", done, 1);
      check("zero_forced", forced, 0);
      req = '0;
      tick();
      check("zero_done_gone", done, 0);

      // Abort: requester 3, len 10, dropped after 4 forced cycles.
      set_req(3, 4'h9, 8'd10);
      req = 4'b1000;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("abort_grant", grant, 4'b1000);
         check("abort_out", out_val, 4'h9);
      end
      req = '0;
      tick();
      check("abort_done", done, 1);
      check_idle("abort_rel", 4'h5);
      tick();
      check("abort_done_once", done, 0);
      tick();
      check("abort_done_none", done, 0);

      // Async reset during a 5-cycle force on requester 2.
      set_req(2, 4'hA, 8'd5);
      req = 4'b0100;
      tick();
      check("mid_grant", grant, 4'b0100);
      tick();
      check("mid_forced", forced, 1);
      #2;
      rst = 1'b1;
      #1;
      check_idle("mid_rst", 4'h5);
      tick();
      rst = 1'b0;
      set_req(0, 4'h6, 8'd1);
      req = 4'b0101;
      tick();
      check("mid_next_grant", grant, 4'b0001);
      check("mid_next_out", out_val, 4'h6);
      req = '0;
      tick();
      check("mid_next_done", done, 1);
      tick();

      // Latched value: requester 1, len 4, inputs change mid-force.
      set_req(1, 4'h3, 8'd4);
      req = 4'b0010;
      tick();
      check("latch_grant", grant, 4'b0010);
      check("latch_out0", out_val, 4'h3);
      set_req(1, 4'hC, 8'd4);
      func_val = 4'hE;
      #1;
      check("latch_out_comb", out_val, 4'h3);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("latch_out", out_val, 4'h3);
         check("latch_forced", forced, 1);
      end
      tick();
      check("latch_done", done, 1);
      check("latch_rel_out", out_val, 4'hE);
      req = '0;
      func_val = 4'h2;
      #1;
      check("latch_rel_comb", out_val, 4'h2);
      tick();
      check_idle("latch_idle", 4'h2);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/force_arbiter.md
# force_arbiter

Time-shared override controller for a W-bit net whose normal value comes from a functional driver. Up to NREQ requesters ask to override the net with their own value for a given number of cycles. The block grants one requester at a time in round-robin order, drives that value for the requested duration, then releases the net back to the functional driver. It sits between the functional driver and the net's consumers, and replaces ad-hoc procedural force/release with a sequenced, arbitrated mechanism.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 4, net width in bits
- LW, 8, width of each hold-length field
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- func_val  input  W  functional (unforced) value of the net
- req  input  NREQ  per-requester override request, level-held until granted and done
- req_val  input  NREQ*W  packed override values; requester i uses bits [i*W +: W]
- req_len  input  NREQ*LW  packed hold lengths in cycles; requester i uses bits [i*LW +: LW]
- grant  output  NREQ  one-hot registered grant; all zero when idle
- forced  output  1  high while an override is being driven
- done  output  1  one-cycle pulse when an override is released
- out_val  output  W  net value: held override when forced=1, else func_val (combinational mux)

## Operation
- FSM states: IDLE, FORCE, RELEASE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from last+1 (mod NREQ).
  - Latch that requester's req_val into hold_val and its req_len into cnt. A length of 0 is treated as 1.
  - Set grant[i], set forced, go to FORCE.
  - If no request, stay in IDLE.
- FORCE:
  - out_val = hold_val.
  - cnt decrements each cycle.
  - When cnt==1 at a clock edge, go to RELEASE.
  - If req[granted] drops at any FORCE cycle (abort), go to RELEASE at that edge regardless of cnt.
  - req_val changes after the grant are ignored; the value is latched.
- RELEASE:
  - grant=0, forced=0, done=1 for exactly one cycle.
  - out_val = func_val.
  - last = granted index.
  - Unconditionally return to IDLE; no arbitration happens in RELEASE.
- Round-robin: last resets to NREQ-1, so requester 0 has first priority after reset. A requester that keeps req high is served again only after every other pending requester has been served.
- Widths: cnt is LW bits. hold_val is W bits. Index registers are clog2(NREQ) bits.
- Reset (asynchronous, any state, including mid-FORCE):
  - state=IDLE, grant=0, forced=0, done=0, cnt=0, hold_val=0, last=NREQ-1.
  - out_val immediately follows func_val.

## Timing
- Request sampled at edge k in IDLE → grant/forced high from edge k through edge k+len. done is high for the cycle after edge k+len. IDLE resumes at edge k+len+1.
- Total override window is exactly len cycles (1 cycle if len=0). Maximum is 2^LW-1 cycles.
- Back-to-back requests: minimum spacing between successive grants is len+2 edges (one RELEASE cycle plus one IDLE sampling edge).
- Abort: req[granted] low at edge m in FORCE → RELEASE at m, done during cycle m..m+1.
- A requester raising req on the same edge another is granted waits for the next IDLE.
- func_val changes during FORCE do not affect out_val. During IDLE and RELEASE they propagate combinationally.
- done and forced are never high in the same cycle. grant is never multi-hot.

## Test plan
- Reset then idle: rst pulse, func_val=4'h5, req=0 → grant=0, forced=0, done=0, out_val=4'h5 for 10 cycles.
- Single override: req[2]=1, req_val[2]=4'h1, req_len[2]=3 → grant=4'b0100 and out_val=4'h1 for exactly 3 cycles, then done for 1 cycle, then out_val=func_val.
- Round-robin fairness: req=4'b1111 held, all lengths 1 → grant sequence 0,1,2,3,0 with 3-cycle spacing between grants.
- Zero length and abort:
  - req_len=0 → 1-cycle force.
  - req_len=10 with req dropped after 4 forced cycles → release after 4 cycles, done pulses once.
- Reset mid-FORCE: assert rst asynchronously (between edges) at cycle 2 of a 5-cycle force → grant/forced drop without waiting for a clock, out_val=func_val, and the next grant goes to requester 0.
- Latched value: change req_val[1] and func_val during FORCE → out_val holds the originally latched value until release.
